mem_access_unit: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns the latched access fields into a single-outstanding req/ack transaction on the data-memory/IO bus: address, write data, read/write and IO selects, width, sign.
- Produces byte lanes and store-data replication, and aligns and sign/zero-extends load data.
- Stalls the pipeline until the access completes and flags misaligned addresses for CP0.

---
 rtl/cpu_mem_pkg.sv | 8 +
 rtl/mem_lane_formatter.sv | 25 ++
 rtl/mem_access_unit.sv | 108 ++++++++++
 tb/tb_mem_access_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: width codes, MEM-stage FSM encoding and bus timeout default
package cpu_mem_pkg;
  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;
  localparam int DEFAULT_TIMEOUT = 255;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
endpackage

// File: rtl/mem_lane_formatter.sv
// mem_lane_formatter: byte enables, store-data replication and load lane alignment/extension
module mem_lane_formatter
  import cpu_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  width,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);
  logic [31:0] shifted;
  logic is_byte, is_half;
  assign shifted = rdata >> {addr_lo, 3'b000};
  assign is_byte = width == WIDTH_BYTE;
  assign is_half = width == WIDTH_HALF;
  always_comb begin
    be = is_byte ? 4'b0001 << addr_lo : is_half ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_rep = is_byte ? {4{wdata[7:0]}} : is_half ? {2{wdata[15:0]}} : wdata;
    rdata_ext = is_byte ? {{24{sign & shifted[7]}}, shifted[7:0]} :
                is_half ? {{16{sign & shifted[15]}}, shifted[15:0]} : rdata;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage single-outstanding data/IO bus access with stall and misalignment report.
// Define MEM_TIMEOUT_EN to abort a bus access after TIMEOUT_CYCLES un-acked BUSY cycles.
module mem_access_unit
  import cpu_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        acc_valid,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [1:0]  data_width,
  input  logic        mem_sign,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_io,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        addr_exc,
  output logic        exc_is_store,
  output logic        bus_err
);
  state_t state, next_state;
  logic req, mis, go, timeout, finish, is_write;
  logic [1:0] lat_lo, lat_width, f_lo;
  logic lat_sign;
  logic [3:0] f_be;
  logic [31:0] f_wdata, f_rdata;
  assign is_write = mem_write | io_write;
  assign req = acc_valid & (mem_read | mem_write | io_read | io_write);
  assign mis = (data_width == WIDTH_HALF && addr[0]) || (data_width[1] && addr[1:0] != 2'b00);
  assign go = state == S_IDLE && req && !mis;
  assign finish = state == S_BUSY && (bus_ack || timeout);
  assign stall = go || state == S_BUSY;
  // The formatter sees live fields while idle and the latched access once on the bus.
  assign f_lo = state == S_IDLE ? addr[1:0] : lat_lo;
  mem_lane_formatter u_fmt (
    .addr_lo(f_lo), .width(state == S_IDLE ? data_width : lat_width), .sign(lat_sign),
    .wdata(wdata), .rdata(bus_rdata), .be(f_be), .wdata_rep(f_wdata), .rdata_ext(f_rdata)
  );
`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt;
  assign timeout = state == S_BUSY && !bus_ack && cnt == 8'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt <= '0;
      bus_err <= 1'b0;
    end else begin
      cnt <= go ? 8'd0 : (state == S_BUSY && !bus_ack) ? cnt + 8'd1 : cnt;
      bus_err <= timeout;
    end
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    next_state = state == S_IDLE ? (go ? S_BUSY : S_IDLE) :
                 state == S_BUSY ? (finish ? S_DONE : S_BUSY) : S_IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_io <= 1'b0;
      bus_addr <= '0;
      bus_be <= '0;
      bus_wdata <= '0;
      load_data <= '0;
      load_valid <= 1'b0;
      addr_exc <= 1'b0;
      exc_is_store <= 1'b0;
      lat_lo <= '0;
      lat_width <= '0;
      lat_sign <= 1'b0;
    end else begin
      addr_exc <= state == S_IDLE && req && mis;
      exc_is_store <= state == S_IDLE && req && mis && is_write;
      load_valid <= state == S_BUSY && bus_ack && !bus_we;
      if (go) begin
        bus_req <= 1'b1;
        bus_we <= is_write;
        bus_io <= io_read | io_write;
        bus_addr <= {addr[31:2], 2'b00};
        bus_be <= f_be;
        bus_wdata <= f_wdata;
        lat_lo <= addr[1:0];
        lat_width <= data_width;
        lat_sign <= mem_sign;
      end else if (finish) bus_req <= 1'b0;
      if (state == S_BUSY && bus_ack && !bus_we) load_data <= f_rdata;
      else if (timeout) load_data <= '0;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors with a queue scoreboard checked by a negedge monitor
module tb_mem_access_unit;
  logic clock = 1'b0, reset = 1'b1;
  logic acc_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, io_read = 1'b0, io_write = 1'b0;
  logic mem_sign = 1'b0, bus_ack = 1'b0;
  logic [1:0] data_width = 2'b00;
  logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
  logic bus_req, bus_we, bus_io, stall, load_valid, addr_exc, exc_is_store, bus_err;
  logic [3:0] bus_be;
  logic [31:0] bus_addr, bus_wdata, load_data;
  typedef struct packed {logic we; logic io; logic [31:0] addr; logic [3:0] be; logic [31:0] wd;} bus_t;
  bus_t bus_q[$];
  logic [31:0] load_q[$];
  logic exc_q[$];
  logic err_q[$];
  int checks = 0, errors = 0, stall_total = 0;
  logic req_d = 1'b0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .acc_valid(acc_valid), .addr(addr), .wdata(wdata),
    .mem_read(mem_read), .mem_write(mem_write), .io_read(io_read), .io_write(io_write),
    .data_width(data_width), .mem_sign(mem_sign), .bus_req(bus_req), .bus_we(bus_we),
    .bus_io(bus_io), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall(stall), .load_data(load_data),
    .load_valid(load_valid), .addr_exc(addr_exc), .exc_is_store(exc_is_store), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    req_d <= bus_req;
    if (stall) stall_total <= stall_total + 1;
    if (!reset) begin
      if (bus_req && !req_d) begin
        if (bus_q.size() == 0) chk("bus_unexpected", bus_req, 1'b0);
        else chk("bus_fields", {bus_we, bus_io, bus_addr, bus_be, bus_wdata}, bus_q.pop_front());
      end
      if (load_valid) begin
        if (load_q.size() == 0) chk("load_unexpected", load_valid, 1'b0);
        else chk("load_data", load_data, load_q.pop_front());
      end
      if (addr_exc) begin
        if (exc_q.size() == 0) chk("exc_unexpected", addr_exc, 1'b0);
        else chk("exc_is_store", exc_is_store, exc_q.pop_front());
      end
      if (bus_err) begin
        if (err_q.size() == 0) chk("err_unexpected", bus_err, 1'b0);
        else begin
          chk("err_expected", err_q.pop_front(), bus_err);
          chk("err_load_zero", {load_valid, load_data}, 33'h0);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] a, wd, input logic [3:0] ops, input logic [1:0] w, input logic s);
    addr = a;
    wdata = wd;
    {mem_read, mem_write, io_read, io_write} = ops;
    data_width = w;
    mem_sign = s;
    acc_valid = 1'b1;
  endtask

  // Called just after a rising edge; ack arrives after dly un-acked BUSY cycles.
  task automatic access(input string name, input logic [31:0] a, wd, rd, input logic [3:0] ops,
                        input logic [1:0] w, input logic s, input int dly, input logic we_e, io_e,
                        input logic [3:0] be_e, input logic [31:0] wd_e, ld_e, input int stall_e);
    int st0;
    bus_q.push_back('{we_e, io_e, {a[31:2], 2'b00}, be_e, wd_e});
    if (!we_e) load_q.push_back(ld_e);
    st0 = stall_total;
    drive(a, wd, ops, w, s);
    @(posedge clock); #1 acc_valid = 1'b0;
    repeat (dly) @(posedge clock);
    #1 bus_ack = 1'b1;
    bus_rdata = rd;
    @(posedge clock); #1 bus_ack = 1'b0;
    acc_valid = 1'b1;
    @(posedge clock); #1 acc_valid = 1'b0;
    chk({name, "_stall_cycles"}, stall_total - st0, stall_e);
  endtask

  task automatic misaligned(input string name, input logic [31:0] a, input logic [3:0] ops,
                            input logic [1:0] w, input logic valid, input logic st_e);
    if (valid) exc_q.push_back(st_e);
    drive(a, 32'h0, ops, w, 1'b0);
    acc_valid = valid;
    @(negedge clock);
    chk({name, "_no_stall_req"}, {stall, bus_req}, 2'b00);
    @(posedge clock); #1 acc_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    int st0;
    @(negedge clock);
    chk("reset_bus", {bus_req, bus_we, bus_io, bus_addr, bus_be, bus_wdata}, '0);
    chk("reset_misc", {stall, load_data, load_valid, addr_exc, exc_is_store, bus_err}, '0);
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;
    access("word_store", 32'h100, 32'hDEADBEEF, 32'h0, 4'b0100, 2'b10, 1'b0, 3,
           1'b1, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0, 5);
    access("byte_load_s", 32'h203, 32'h0, 32'h80112233, 4'b1000, 2'b00, 1'b1, 0,
           1'b0, 1'b0, 4'b1000, 32'h0, 32'hFFFFFF80, 2);
    access("byte_load_u", 32'h203, 32'h0, 32'h80112233, 4'b1000, 2'b00, 1'b0, 0,
           1'b0, 1'b0, 4'b1000, 32'h0, 32'h00000080, 2);
    access("half_store", 32'h2, 32'h0000ABCD, 32'h0, 4'b0100, 2'b01, 1'b0, 1,
           1'b1, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0, 3);
    access("io_half_load", 32'h2, 32'h0, 32'h80017FFF, 4'b1010, 2'b01, 1'b1, 2,
           1'b0, 1'b1, 4'b1100, 32'h0, 32'hFFFF8001, 4);
    access("rw_store", 32'h10, 32'h12345678, 32'h0, 4'b1100, 2'b10, 1'b0, 0,
           1'b1, 1'b0, 4'b1111, 32'h12345678, 32'h0, 2);
    access("w11_load", 32'h20, 32'h0, 32'h87654321, 4'b1000, 2'b11, 1'b1, 1,
           1'b0, 1'b0, 4'b1111, 32'h0, 32'h87654321, 3);
    access("half_load_u", 32'h0, 32'h0, 32'h1234F00D, 4'b1000, 2'b01, 1'b0, 0,
           1'b0, 1'b0, 4'b0011, 32'h0, 32'h0000F00D, 2);
    access("byte_store", 32'h1, 32'h000000A5, 32'h0, 4'b0100, 2'b00, 1'b0, 0,
           1'b1, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0, 2);
    chk("load_hold", load_data, 32'h0000F00D);
    misaligned("mis_word_load", 32'h101, 4'b1000, 2'b10, 1'b1, 1'b0);
    misaligned("mis_half_store", 32'h3, 4'b0100, 2'b01, 1'b1, 1'b1);
    misaligned("mis_io_w11_store", 32'h2, 4'b0001, 2'b11, 1'b1, 1'b1);
    misaligned("mis_not_valid", 32'h1, 4'b1000, 2'b01, 1'b0, 1'b0);
    access("ack_at_limit", 32'h1, 32'h0, 32'h0000C300, 4'b1000, 2'b00, 1'b1, 3,
           1'b0, 1'b0, 4'b0010, 32'h0, 32'hFFFFFFC3, 5);
    // reset in the middle of BUSY, then a stale ack while idle
    bus_q.push_back('{1'b0, 1'b0, 32'h40, 4'b1111, 32'h0});
    drive(32'h40, 32'h0, 4'b1000, 2'b10, 1'b0);
    @(posedge clock); #1 acc_valid = 1'b0;
    @(negedge clock); #1 reset = 1'b1;
    #1 chk("reset_abort", {bus_req, stall, bus_be}, '0);
    @(posedge clock); #1 reset = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'h55555555;
    @(posedge clock); #1 bus_ack = 1'b0;
    @(negedge clock);
    chk("stale_ack_idle", {bus_req, stall, load_valid}, 3'b000);
    @(posedge clock); #1;
    access("after_reset", 32'h44, 32'h0, 32'h0BADF00D, 4'b1000, 2'b10, 1'b1, 1,
           1'b0, 1'b0, 4'b1111, 32'h0, 32'h0BADF00D, 3);
    // no ack at all
    bus_q.push_back('{1'b0, 1'b0, 32'h80, 4'b1111, 32'h0});
    st0 = stall_total;
    drive(32'h80, 32'h0, 4'b1000, 2'b10, 1'b0);
`ifdef MEM_TIMEOUT_EN
    err_q.push_back(1'b1);
    @(posedge clock); #1 acc_valid = 1'b0;
    repeat (6) @(posedge clock);
    #1 chk("timeout_stall_cycles", stall_total - st0, 5);
    chk("timeout_released", {bus_req, stall}, 2'b00);
`else
    @(posedge clock); #1 acc_valid = 1'b0;
    repeat (10) @(posedge clock);
    #1 chk("no_timeout_stall_cycles", stall_total - st0, 11);
    chk("no_timeout_held", {bus_req, stall, bus_err}, 3'b110);
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
`endif
    repeat (3) @(posedge clock);
    chk("queues_empty", bus_q.size() + load_q.size() + exc_q.size() + err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
